// File: rtl/fp_priority_encoder_pipe.sv
// ---------------------------------------------------------------------------
// fp_priority_encoder_pipe
//
// Pipelined priority encoder / leading-zero counter for the FPU normalisation
// paths. It finds the highest set bit (LSB_PRIORITY=0) or the lowest set bit
// (LSB_PRIORITY=1) of in_data. It returns that index, an all-zero flag and the
// matching leading- or trailing-zero count. A sideband tag travels alongside
// each word and comes back unchanged with its result.
//
// The encoder is a log2(WIDTH)-deep tree of 2-input encode/merge cells. There
// are three stage slots: input, mid and output. The mid slot sits after tree
// level WIDTHAD/2 (rounded down).
//   STAGES=1 : only the output register is real.
//   STAGES=2 : mid and output registers are real.
//   STAGES=3 : input, mid and output registers are real.
// Slots that are not real become wires, so latency equals STAGES.
//
// Every real stage holds a valid bit. A stage loads whenever it is empty or
// the stage after it is loading, so bubbles collapse. in_ready is therefore
// combinational from out_ready; there is no skid buffer.
//
// Ports
//   clock, reset          rising-edge clock, synchronous active-high reset
//   in_valid / in_ready   input handshake
//   in_data, in_tag       word to encode and its sideband tag
//   out_valid / out_ready output handshake
//   out_q                 index of the priority bit (0 when in_data was zero)
//   out_zero              in_data was all zeros
//   out_count             leading-zero count (MSB mode) or trailing-zero
//                         count (LSB mode); WIDTH when in_data was zero
//   out_tag               tag that entered with this word
// ---------------------------------------------------------------------------
module fp_priority_encoder_pipe #(
  parameter int WIDTH        = 32,
  parameter int WIDTHAD      = 5,
  parameter int LSB_PRIORITY = 0,
  parameter int STAGES       = 1,
  parameter int TAG_W        = 8
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   in_data,
  input  logic [TAG_W-1:0]   in_tag,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [WIDTHAD-1:0] out_q,
  output logic               out_zero,
  output logic [WIDTHAD:0]   out_count,
  output logic [TAG_W-1:0]   out_tag
);

  // Tree level at which the mid slot cuts the tree. Level 0 is the raw input,
  // seen as WIDTH one-bit nodes that carry only a zero flag.
  localparam int SPLIT = WIDTHAD / 2;
  // Width of the level-SPLIT node vector. Each node is {zero, q[SPLIT-1:0]}.
  localparam int MID_W = (WIDTH >> SPLIT) * (SPLIT + 1);
  localparam logic [WIDTHAD:0] FULL_COUNT = (WIDTHAD + 1)'(WIDTH);
  localparam logic [WIDTHAD:0] TOP_INDEX  = (WIDTHAD + 1)'(WIDTH - 1);

  // Elaboration-time parameter checks
  if (STAGES < 1 || STAGES > 3) begin : g_bad_stages
    $error("fp_priority_encoder_pipe: STAGES must be 1, 2 or 3");
  end
  if (WIDTH < 2 || WIDTH > 64 || (WIDTH & (WIDTH - 1)) != 0) begin : g_bad_width
    $error("fp_priority_encoder_pipe: WIDTH must be a power of two in 2..64");
  end
  if (WIDTHAD != $clog2(WIDTH)) begin : g_bad_widthad
    $error("fp_priority_encoder_pipe: WIDTHAD must equal log2(WIDTH)");
  end

  // Input slot outputs
  logic               in_s_v;
  logic [WIDTH-1:0]   in_s_data;
  logic [TAG_W-1:0]   in_s_tag;
  logic               ready_in;

  // Mid slot: level-SPLIT nodes computed from the input slot, then held
  logic [MID_W-1:0]   mid_src;
  logic [MID_W-1:0]   mid_nodes;
  logic               mid_v;
  logic [TAG_W-1:0]   mid_tag;
  logic               ready_mid;

  // Output slot
  logic               ready_out;
  logic               root_zero;
  logic [WIDTHAD-1:0] root_q;
  logic [WIDTHAD:0]   root_count;

  // -------------------------------------------------------------------------
  // Input slot. It is a real register only in the 3-stage build. Otherwise it
  // is a straight wire from the ports and passes the mid slot's ready back.
  // -------------------------------------------------------------------------
  if (STAGES == 3) begin : g_in_reg
    always_ff @(posedge clock) begin
      if (reset) begin
        in_s_v    <= 1'b0;
        in_s_data <= '0;
        in_s_tag  <= '0;
      end else if (ready_in) begin
        in_s_v <= in_valid;
        if (in_valid) begin
          in_s_data <= in_data;
          in_s_tag  <= in_tag;
        end
      end
    end
    assign ready_in = ~in_s_v | ready_mid;
  end else begin : g_in_wire
    assign in_s_v    = in_valid;
    assign in_s_data = in_data;
    assign in_s_tag  = in_tag;
    assign ready_in  = ready_mid;
  end

  // -------------------------------------------------------------------------
  // Encode tree. At level k, node i combines children 2i (lower half) and
  // 2i+1 (upper half) of level k-1. Each level-k node is k+1 bits wide:
  // {zero, q[k-1:0]}.
  //
  // 'sel' is the new leading q bit. It is 1 exactly when the result comes
  // from the upper half:
  //   MSB mode: the upper half is non-zero.
  //   LSB mode: the lower half is all zero.
  // When everything is zero, the LSB rule yields all-ones. The output slot
  // forces q to 0 in that case.
  //
  // Levels 1..SPLIT read from the input slot. Levels SPLIT+1..WIDTHAD read
  // from the mid slot.
  // -------------------------------------------------------------------------
  for (genvar k = 1; k <= WIDTHAD; k++) begin : lv
    localparam int NN = WIDTH >> k;
    logic [NN*(k+1)-1:0] nodes;
    logic [2*NN*k-1:0]   kids;

    if (k == SPLIT + 1) begin : g_from_mid
      assign kids = mid_nodes;
    end else if (k == 1) begin : g_from_input
      assign kids = ~in_s_data;
    end else begin : g_from_prev
      assign kids = lv[k-1].nodes;
    end

    for (genvar i = 0; i < NN; i++) begin : node
      logic [k-1:0] lo;
      logic [k-1:0] hi;
      logic         sel;

      assign lo  = kids[2*i*k +: k];
      assign hi  = kids[(2*i+1)*k +: k];
      assign sel = (LSB_PRIORITY != 0) ? lo[k-1] : ~hi[k-1];

      if (k == 1) begin : g_leaf
        assign nodes[i*2 +: 2] = {lo[0] & hi[0], sel};
      end else begin : g_merge
        assign nodes[i*(k+1) +: k+1] =
          {lo[k-1] & hi[k-1], sel, sel ? hi[k-2:0] : lo[k-2:0]};
      end
    end
  end

  // Level-SPLIT view of the current input word
  if (SPLIT == 0) begin : g_mid_src_raw
    assign mid_src = ~in_s_data;
  end else begin : g_mid_src_tree
    assign mid_src = lv[SPLIT].nodes;
  end

  // -------------------------------------------------------------------------
  // Mid slot. It is a real register when STAGES >= 2 and holds the
  // partially reduced tree and the tag. Otherwise it is a wire, and the whole
  // tree is combinational into the output register.
  // -------------------------------------------------------------------------
  if (STAGES >= 2) begin : g_mid_reg
    always_ff @(posedge clock) begin
      if (reset) begin
        mid_v     <= 1'b0;
        mid_nodes <= '0;
        mid_tag   <= '0;
      end else if (ready_mid) begin
        mid_v <= in_s_v;
        if (in_s_v) begin
          mid_nodes <= mid_src;
          mid_tag   <= in_s_tag;
        end
      end
    end
    assign ready_mid = ~mid_v | ready_out;
  end else begin : g_mid_wire
    assign mid_v     = in_s_v;
    assign mid_nodes = mid_src;
    assign mid_tag   = in_s_tag;
    assign ready_mid = ready_out;
  end

  // Root of the tree, turned into index and count. A zero word reports index
  // 0 and count WIDTH in both modes.
  assign root_zero  = lv[WIDTHAD].nodes[WIDTHAD];
  assign root_q     = root_zero ? '0 : lv[WIDTHAD].nodes[WIDTHAD-1:0];
  assign root_count = root_zero             ? FULL_COUNT :
                      (LSB_PRIORITY != 0)   ? {1'b0, root_q} :
                                              TOP_INDEX - {1'b0, root_q};

  // -------------------------------------------------------------------------
  // Output register. It is always present. Results hold while out_ready is
  // low, and a new result loads as soon as the current one is taken.
  // -------------------------------------------------------------------------
  assign ready_out = ~out_valid | out_ready;

  always_ff @(posedge clock) begin
    if (reset) begin
      out_valid <= 1'b0;
      out_q     <= '0;
      out_zero  <= 1'b0;
      out_count <= '0;
      out_tag   <= '0;
    end else if (ready_out) begin
      out_valid <= mid_v;
      if (mid_v) begin
        out_q     <= root_q;
        out_zero  <= root_zero;
        out_count <= root_count;
        out_tag   <= mid_tag;
      end
    end
  end

  // Nothing is accepted while reset is asserted
  assign in_ready = ready_in & ~reset;

endmodule

// File: tb/tb_fp_priority_encoder_pipe.sv
// ---------------------------------------------------------------------------
// tb_fp_priority_encoder_pipe
//
// Drives one shared input stream and one shared out_ready into a set of
// encoder builds (widths 2/8/32/64, both priority modes, STAGES 1..3). Each
// build has its own scoreboard. A word enters the scoreboard queue when the
// build accepts it. Whenever a result is presented, the head of the queue is
// encoded by a plain bit-scan reference and compared with the DUT. The
// reference is checked against hand-computed values, and directed words are
// also checked against literal expected results.
// ---------------------------------------------------------------------------
module tb_fp_priority_encoder_pipe;

  localparam int NCFG = 14;
  localparam int CFG_W [NCFG] = '{32, 32, 32, 32, 8, 8, 8, 8, 8, 8, 64, 64, 2, 2};
  localparam int CFG_L [NCFG] = '{ 0,  0,  1,  1, 0, 0, 0, 1, 1, 1,  0,  1, 1, 0};
  localparam int CFG_S [NCFG] = '{ 1,  2,  3,  1, 1, 2, 3, 1, 2, 3,  3,  2, 2, 3};

  logic        clock;
  logic        reset;
  logic        in_valid;
  logic [63:0] in_data;
  logic [7:0]  in_tag;
  logic        out_ready;
  bit          final_chk;

  int errors = 0;
  int checks = 0;

  // Main-sequence scratch
  int          mq;
  int          mcnt;
  bit          mz;
  int          idx;
  int          cycn;
  int          p0;
  bit          fell;
  bit          acc;
  logic [63:0] r;

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Every comparison goes through here
  task automatic checkOutput(input string name, input logic [63:0] actual,
                             input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  // Reference encoder: a plain scan of the bits
  function automatic void ref_enc(input logic [63:0] d, input int w, input bit lsb,
                                  output int q, output bit z, output int cnt);
    q = 0;
    z = 1'b1;
    for (int b = 0; b < w; b++) begin
      if (d[b]) begin
        if (!lsb || z) q = b;
        z = 1'b0;
      end
    end
    cnt = z ? w : (lsb ? q : w - 1 - q);
  endfunction

  // Advance n clocks, then settle 1 time unit past the edge
  task automatic idle(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  // Present one word for a single cycle, then let every build drain
  task automatic applyStimulus(input logic [63:0] d, input logic [7:0] t);
    in_valid = 1'b1;
    in_data  = d;
    in_tag   = t;
    idle(1);
    in_valid = 1'b0;
    idle(5);
  endtask

  // One DUT per configuration, each with its own scoreboard monitor
  for (genvar c = 0; c < NCFG; c++) begin : g_dut
    localparam int W   = CFG_W[c];
    localparam int WAD = $clog2(W);
    localparam int LSB = CFG_L[c];
    localparam int STG = CFG_S[c];

    typedef struct {
      logic [63:0] d;
      logic [7:0]  tag;
      int          cyc;
      int          lows;
    } exp_t;

    logic           ir;
    logic           ov;
    logic [WAD-1:0] oq;
    logic           oz;
    logic [WAD:0]   ocnt;
    logic [7:0]     otag;

    exp_t sb[$];
    int   cyc = 0;
    int   lows = 0;
    int   pops = 0;
    int   last_q = 0;
    int   last_cnt = 0;
    bit   last_z = 1'b0;
    logic [7:0] last_tag = 8'h00;
    bit   stalled = 1'b0;
    bit   prev_rst = 1'b0;
    bit   final_done = 1'b0;

    fp_priority_encoder_pipe #(
      .WIDTH(W), .WIDTHAD(WAD), .LSB_PRIORITY(LSB), .STAGES(STG), .TAG_W(8)
    ) u_dut (
      .clock    (clock),
      .reset    (reset),
      .in_valid (in_valid),
      .in_ready (ir),
      .in_data  (in_data[W-1:0]),
      .in_tag   (in_tag),
      .out_valid(ov),
      .out_ready(out_ready),
      .out_q    (oq),
      .out_zero (oz),
      .out_count(ocnt),
      .out_tag  (otag)
    );

    // Sample on the falling edge. This is where we decide what the next
    // rising edge will transfer.
    always @(negedge clock) begin : mon
      int   eq;
      int   ecnt;
      bit   ez;
      exp_t h;
      cyc++;
      if (prev_rst) begin
        checkOutput($sformatf("c%0d reset out_valid", c), ov, 0);
        checkOutput($sformatf("c%0d reset out_q", c), oq, 0);
        checkOutput($sformatf("c%0d reset out_zero", c), oz, 0);
        checkOutput($sformatf("c%0d reset out_count", c), ocnt, 0);
        checkOutput($sformatf("c%0d reset out_tag", c), otag, 0);
      end
      if (reset) begin
        checkOutput($sformatf("c%0d in_ready during reset", c), ir, 0);
        sb.delete();
        stalled = 1'b0;
      end else begin
        if (prev_rst)
          checkOutput($sformatf("c%0d in_ready after reset", c), ir, 1);
        if (ov) begin
          if (sb.size() == 0) begin
            checkOutput($sformatf("c%0d unexpected out_valid", c), ov, 0);
          end else begin
            h = sb[0];
            ref_enc(h.d, W, LSB != 0, eq, ez, ecnt);
            checkOutput($sformatf("c%0d out_q tag=%0h", c, h.tag), oq, eq);
            checkOutput($sformatf("c%0d out_zero tag=%0h", c, h.tag), oz, ez);
            checkOutput($sformatf("c%0d out_count tag=%0h", c, h.tag), ocnt, ecnt);
            checkOutput($sformatf("c%0d out_tag", c), otag, h.tag);
            if (!stalled && h.lows == lows)
              checkOutput($sformatf("c%0d latency", c), cyc - h.cyc, STG);
            if (out_ready) begin
              pops++;
              last_q   = int'(oq);
              last_cnt = int'(ocnt);
              last_z   = oz;
              last_tag = otag;
              void'(sb.pop_front());
            end
          end
          stalled = !out_ready;
        end else begin
          if (stalled)
            checkOutput($sformatf("c%0d out_valid held while stalled", c), ov, 1);
          stalled = 1'b0;
        end
        if (!out_ready) lows++;
        if (in_valid && ir) sb.push_back('{in_data, in_tag, cyc, lows});
      end
      if (final_chk && !final_done) begin
        checkOutput($sformatf("c%0d words left in flight", c), sb.size(), 0);
        final_done = 1'b1;
      end
      prev_rst = reset;
    end
  end

  initial begin
    reset     = 1'b1;
    in_valid  = 1'b0;
    in_data   = '0;
    in_tag    = '0;
    out_ready = 1'b1;
    final_chk = 1'b0;
    idle(3);
    reset = 1'b0;
    idle(2);

    // Pin the reference model with hand-computed values
    ref_enc(64'h0000_0000_0001_0000, 32, 1'b0, mq, mz, mcnt);
    checkOutput("model msb q", mq, 16);
    checkOutput("model msb count", mcnt, 15);
    ref_enc(64'h0, 32, 1'b1, mq, mz, mcnt);
    checkOutput("model zero flag", mz, 1);
    checkOutput("model zero count", mcnt, 32);
    ref_enc(64'h0000_0000_0000_0A00, 32, 1'b1, mq, mz, mcnt);
    checkOutput("model lsb q", mq, 9);
    ref_enc(64'h8000_0000_0000_0001, 64, 1'b0, mq, mz, mcnt);
    checkOutput("model w64 msb q", mq, 63);

    // Directed words with literal expectations
    p0 = g_dut[0].pops;
    applyStimulus(64'h0000_0000_0001_0000, 8'h5A);
    checkOutput("dir c0 one result", g_dut[0].pops - p0, 1);
    checkOutput("dir c0 q", g_dut[0].last_q, 16);
    checkOutput("dir c0 count", g_dut[0].last_cnt, 15);
    checkOutput("dir c0 zero", g_dut[0].last_z, 0);
    checkOutput("dir c0 tag", g_dut[0].last_tag, 8'h5A);
    checkOutput("dir c3 lsb q", g_dut[3].last_q, 16);
    checkOutput("dir c3 lsb count", g_dut[3].last_cnt, 16);

    applyStimulus(64'h0, 8'h01);
    checkOutput("dir c1 zero flag", g_dut[1].last_z, 1);
    checkOutput("dir c1 zero q", g_dut[1].last_q, 0);
    checkOutput("dir c1 zero count", g_dut[1].last_cnt, 32);
    checkOutput("dir c2 lsb zero q", g_dut[2].last_q, 0);
    checkOutput("dir c2 lsb zero count", g_dut[2].last_cnt, 32);

    applyStimulus(64'h0000_0000_FFFF_FFFF, 8'h02);
    checkOutput("dir c1 ones q", g_dut[1].last_q, 31);
    checkOutput("dir c1 ones count", g_dut[1].last_cnt, 0);

    applyStimulus(64'h0000_0000_0000_0A00, 8'h03);
    checkOutput("dir c2 lsb q", g_dut[2].last_q, 9);
    checkOutput("dir c2 lsb count", g_dut[2].last_cnt, 9);

    applyStimulus(64'h0000_0000_8000_0000, 8'h04);
    checkOutput("dir c2 top q", g_dut[2].last_q, 31);
    checkOutput("dir c2 top count", g_dut[2].last_cnt, 31);
    checkOutput("dir c10 w64 count", g_dut[10].last_cnt, 32);

    // Every 8-bit value back to back; the wider builds see random upper bits
    for (int v = 0; v < 256; v++) begin
      in_valid = 1'b1;
      r        = {$urandom, $urandom};
      in_data  = {r[63:8], 8'(v)};
      in_tag   = 8'(v);
      idle(1);
    end
    in_valid = 1'b0;
    idle(6);

    // Backpressure: stream tags 0..19, honouring c2's in_ready, with
    // out_ready low in cycles 5..9
    p0   = g_dut[2].pops;
    idx  = 0;
    cycn = 0;
    fell = 1'b0;
    while (idx < 20 && cycn < 200) begin
      in_valid  = 1'b1;
      in_data   = 64'(idx + 1) << idx;
      in_tag    = 8'(idx);
      out_ready = !(cycn >= 5 && cycn <= 9);
      @(negedge clock);
      acc = g_dut[2].ir;
      if (!g_dut[2].ir) fell = 1'b1;
      @(posedge clock);
      #1;
      if (acc) idx++;
      cycn++;
    end
    checkOutput("bp stream completed", idx, 20);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    idle(10);
    checkOutput("bp in_ready fell", fell, 1);
    checkOutput("bp c2 results", g_dut[2].pops - p0, 20);

    // Reset mid-stream with three words in flight in c2
    out_ready = 1'b0;
    p0 = g_dut[2].pops;
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1;
      in_data  = 64'hF0 << i;
      in_tag   = 8'hE0 + 8'(i);
      idle(1);
    end
    in_valid = 1'b0;
    reset    = 1'b1;
    idle(1);
    reset     = 1'b0;
    out_ready = 1'b1;
    idle(10);
    checkOutput("mid-reset c2 no results", g_dut[2].pops - p0, 0);

    // Random traffic with random backpressure
    for (int i = 0; i < 12000; i++) begin
      in_valid  = ($urandom % 4) != 0;
      r         = {$urandom, $urandom};
      in_data   = (($urandom % 16) == 0) ? 64'h0 : (r >> ($urandom % 64));
      in_tag    = 8'($urandom);
      out_ready = ($urandom % 4) != 0;
      idle(1);
    end

    // Drain, then confirm nothing was lost
    in_valid  = 1'b0;
    out_ready = 1'b1;
    idle(20);
    final_chk = 1'b1;
    idle(3);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
